// File: rtl/ccff_config_loader.sv
// ccff_config_loader: streams a bitstream into parallel CCFF chains with a generated prog_clock, then releases user reset.
module ccff_config_loader #(
  parameter int NUM_CHAINS = 10,
  parameter int CHAIN_LEN  = 1024,
  parameter int SETTLE_CYC = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [NUM_CHAINS-1:0]              s_data,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic [NUM_CHAINS-1:0]              ccff_head,
  input  logic [NUM_CHAINS-1:0]              ccff_tail,
  output logic                               prog_clock,
  output logic                               global_resetn,
  output logic                               cfg_busy,
  output logic                               cfg_done,
  output logic [$clog2(CHAIN_LEN+1)-1:0]     bit_count,
  output logic [NUM_CHAINS-1:0]              tail_parity
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int SW = $clog2(SETTLE_CYC + 2);
  localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, PULSE = 3'd2, SETTLE = 3'd3, DONE = 3'd4;
  localparam logic [CW-1:0] LAST_COUNT = CW'(CHAIN_LEN);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC > 0 ? SETTLE_CYC - 1 : 0);
  logic [2:0]            r_state;
  logic [SW-1:0]         r_settle;
  logic [NUM_CHAINS-1:0] r_head, r_parity;
  logic [CW-1:0]         r_count;
  logic                  r_prog, r_gresetn, r_busy, r_done, r_ready;
  logic [CW-1:0]         w_count_inc;
  logic                  w_last, w_finish;
  assign w_count_inc = r_count + 1'b1;
  assign w_last      = w_count_inc == LAST_COUNT;
  // With no settle period the final pulse hands over straight to DONE.
  assign w_finish    = (r_state == PULSE && w_last && SETTLE_CYC == 0) ||
                       (r_state == SETTLE && r_settle == SETTLE_LAST);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_settle  <= '0;
      r_head    <= '0;
      r_parity  <= '0;
      r_count   <= '0;
      r_prog    <= 1'b0;
      r_gresetn <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: if (start) begin
          r_state   <= SETUP;
          r_ready   <= 1'b1;
          r_busy    <= 1'b1;
          r_done    <= 1'b0;
          r_gresetn <= 1'b0;
          r_count   <= '0;
          r_parity  <= '0;
        end
        SETUP: if (s_valid) begin
          r_head  <= s_data;
          r_prog  <= 1'b1;
          r_ready <= 1'b0;
          r_state <= PULSE;
        end
        PULSE: begin
          r_prog   <= 1'b0;
          r_parity <= r_parity ^ ccff_tail;
          r_count  <= w_count_inc;
          r_settle <= '0;
          r_state  <= w_last ? SETTLE : SETUP;
          r_ready  <= !w_last;
        end
        SETTLE: r_settle <= r_settle + 1'b1;
        default: r_state <= IDLE;
      endcase
      if (w_finish) begin
        r_state   <= DONE;
        r_busy    <= 1'b0;
        r_done    <= 1'b1;
        r_gresetn <= 1'b1;
      end
    end
  end
  assign s_ready       = r_ready;
  assign ccff_head     = r_head;
  assign prog_clock    = r_prog;
  assign global_resetn = r_gresetn;
  assign cfg_busy      = r_busy;
  assign cfg_done      = r_done;
  assign bit_count     = r_count;
  assign tail_parity   = r_parity;
endmodule

// File: tb/tb_ccff_config_loader.sv
// tb_ccff_config_loader: table-driven and randomized loads checked against a scoreboard of accepted words, pulses and tail XOR.
module tb_ccff_config_loader;
  localparam int NC = 10, CL = 8, SC = 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, s_valid = 1'b0;
  logic s_ready, prog_clock, global_resetn, cfg_busy, cfg_done;
  logic [NC-1:0] s_data = '0, ccff_tail = '0, ccff_head, tail_parity;
  logic [3:0] bit_count;
  int checks = 0, failures = 0;
  int cyc, pul, snt;
  always #5 clk = ~clk;
  ccff_config_loader #(.NUM_CHAINS(NC), .CHAIN_LEN(CL), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .ccff_head(ccff_head), .ccff_tail(ccff_tail),
    .prog_clock(prog_clock), .global_resetn(global_resetn), .cfg_busy(cfg_busy),
    .cfg_done(cfg_done), .bit_count(bit_count), .tail_parity(tail_parity)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Scoreboard: each accepted word must appear on ccff_head and produce one pulse the next cycle.
  bit mon_en = 1'b0, m_acc = 1'b0;
  logic [NC-1:0] m_head = '0, m_par = '0;
  int m_cnt = 0;
  always @(negedge clk) if (mon_en) begin
    chk("mon_head", ccff_head, m_head);
    chk("mon_pulse", prog_clock, m_acc);
    chk("mon_count", bit_count, m_cnt);
    chk("mon_parity", tail_parity, m_par);
    chk("mon_release", global_resetn, cfg_done);
    chk("mon_ready_vs_pulse", s_ready & prog_clock, 0);
    if (rst) begin
      m_head = '0; m_par = '0; m_cnt = 0; m_acc = 1'b0;
    end else begin
      if (prog_clock) begin m_par ^= ccff_tail; m_cnt++; end
      m_acc = s_valid && s_ready;
      if (s_valid && s_ready) m_head = s_data;
      if (start && !cfg_busy) begin m_cnt = 0; m_par = '0; end
    end
  end
  task automatic run_load(input int stall_at, input int stall_len, input int tmode, input bit poke,
                          input bit rnd, input int abort_at, output int c, output int pulses, output int sent);
    int stall = 0;
    bit poked = 1'b0;
    c = 0; pulses = 0; sent = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; c = 1;
    chk("start_done_low", cfg_done, 0);
    chk("start_release_low", global_resetn, 0);
    chk("start_busy", cfg_busy, 1);
    chk("start_ready", s_ready, 1);
    chk("start_count_clear", bit_count, 0);
    chk("start_parity_clear", tail_parity, 0);
    while (!cfg_done && c < 300) begin
      if (abort_at > 0 && bit_count == abort_at) begin rst = 1'b1; break; end
      if (prog_clock) pulses++;
      ccff_tail = rnd ? NC'($urandom) : !prog_clock ? '0 :
                  (tmode == 1 && pulses <= 2) ? {NC{1'b1}} : (tmode == 2 && pulses == 1) ? NC'(1) : '0;
      if (s_ready && sent == stall_at && stall < stall_len) begin
        s_valid = 1'b0; stall++;
      end else s_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data = rnd ? NC'($urandom) : NC'(sent + 1);
      start = poke && !poked && bit_count == CL && !cfg_done;
      if (start) poked = 1'b1;
      @(negedge clk);
      if (s_valid && s_ready) sent++;
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0; s_valid = 1'b0; ccff_tail = '0;
  endtask
  typedef struct {
    int stall_at; int stall_len; int tmode; bit poke; int exp_cyc; logic [NC-1:0] exp_par;
  } vec_t;
  vec_t tbl[6];
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{0, 0, 0, 1'b0, 21, 10'h000};
    tbl[1] = '{3, 5, 1, 1'b0, 26, 10'h000};
    tbl[2] = '{0, 0, 2, 1'b0, 21, 10'h001};
    tbl[3] = '{0, 0, 0, 1'b1, 21, 10'h000};
    tbl[4] = '{7, 3, 2, 1'b0, 24, 10'h001};
    tbl[5] = '{1, 1, 1, 1'b1, 22, 10'h000};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; s_valid = 1'b1; mon_en = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_ready", s_ready, 0);
      chk("idle_prog", prog_clock, 0);
      chk("idle_release", global_resetn, 0);
      chk("idle_done", cfg_done, 0);
      chk("idle_busy", cfg_busy, 0);
    end
    @(posedge clk); #1 s_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run_load(tbl[i].stall_at, tbl[i].stall_len, tbl[i].tmode, tbl[i].poke, 1'b0, 0, cyc, pul, snt);
      chk("vec_latency", cyc, tbl[i].exp_cyc);
      chk("vec_done", cfg_done, 1);
      chk("vec_release", global_resetn, 1);
      chk("vec_busy", cfg_busy, 0);
      chk("vec_count", bit_count, CL);
      chk("vec_parity", tail_parity, tbl[i].exp_par);
      chk("vec_pulses", pul, CL);
      chk("vec_words", snt, CL);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold_count", bit_count, CL);
    chk("done_hold_done", cfg_done, 1);
    run_load(0, 0, 0, 1'b0, 1'b0, 5, cyc, pul, snt);
    chk("abort_reached", rst, 1);
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_ready", s_ready, 0);
    chk("abort_prog", prog_clock, 0);
    chk("abort_release", global_resetn, 0);
    chk("abort_busy", cfg_busy, 0);
    chk("abort_done", cfg_done, 0);
    chk("abort_count", bit_count, 0);
    chk("abort_parity", tail_parity, 0);
    chk("abort_head", ccff_head, 0);
    run_load(0, 0, 1, 1'b0, 1'b0, 0, cyc, pul, snt);
    chk("reload_latency", cyc, 21);
    chk("reload_done", cfg_done, 1);
    chk("reload_words", snt, CL);
    chk("reload_parity", tail_parity, 0);
    for (int r = 0; r < 6; r++) begin
      run_load(0, 0, 0, 1'b0, 1'b1, 0, cyc, pul, snt);
      chk("rnd_done", cfg_done, 1);
      chk("rnd_count", bit_count, CL);
      chk("rnd_parity", tail_parity, m_par);
      chk("rnd_pulses", pul, CL);
      chk("rnd_words", snt, CL);
      chk("rnd_min_latency", cyc >= 1 + 2 * CL + SC, 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
